// File: rtl/issue_ctrl.sv
// Issue controller: pops one instruction at a time from the InstQueue into a
// holding register and classifies it as load/store or execute. It dispatches
// the instruction once the target buffer and the ROB both have room. It owns
// the ROB credit count and the allocation tag pointer, and restores both on a
// misprediction flush.
module issue_ctrl #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             IQ_valid,
  input  logic [31:0]      IQ_inst,
  input  logic [31:0]      IQ_pc,
  output logic             IQ_pop,
  input  logic             RS_is_full,
  input  logic             LSB_is_full,
  input  logic             ROB_commit,
  output logic             DSP_valid,
  output logic [31:0]      DSP_inst,
  output logic [31:0]      DSP_pc,
  output logic [TAG_W-1:0] DSP_tag,
  output logic             DSP_to_lsb,
  output logic [TAG_W:0]   credits
);

  localparam logic [TAG_W:0]   CRED_MAX = (TAG_W+1)'(ROB_SIZE);
  localparam logic [TAG_W:0]   CRED_ONE = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FLUSH} state_t;
  typedef enum logic [1:0] {C_ILL, C_RS, C_LSB} cls_t;

  // Opcode decode; anything outside the two known groups is illegal.
  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011: classify = C_LSB;
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b1100011, 7'b0110011, 7'b0010011: classify = C_RS;
      default: classify = C_ILL;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      hold_inst_q, hold_pc_q;
  logic [TAG_W:0]   credits_q, credits_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             dsp_valid_q, dsp_lsb_q;
  logic [31:0]      dsp_inst_q, dsp_pc_q;
  logic [TAG_W-1:0] dsp_tag_q;
  cls_t             cls;
  logic             res_ok, issue_now, drop_now, pop;

  // Issue/drop/pop decisions and next-state selection.
  always_comb begin
    cls       = classify(hold_inst_q[6:0]);
    res_ok    = (cls == C_LSB) ? ~LSB_is_full : ~RS_is_full;
    issue_now = (state_q == S_HOLD) & rdy & ~flush & (cls != C_ILL) &
                (credits_q != '0) & res_ok;
    drop_now  = (state_q == S_HOLD) & rdy & ~flush & (cls == C_ILL);
    pop       = IQ_valid & rdy & ~flush & ~rst &
                ((state_q == S_IDLE) | issue_now | drop_now);
    state_d   = state_q;
    if (flush) begin
      state_d = S_FLUSH;
    end else if (rdy) begin
      case (state_q)
        S_IDLE:  if (pop) state_d = S_HOLD;
        S_HOLD:  if (pop) state_d = S_HOLD;
                 else if (issue_now | drop_now) state_d = S_IDLE;
        S_FLUSH: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Credit and tag bookkeeping; a simultaneous issue and commit cancel out.
  always_comb begin
    credits_d = credits_q;
    tag_d     = tag_q;
    if (flush) begin
      credits_d = CRED_MAX;
      tag_d     = '0;
    end else if (rdy) begin
      if (issue_now) tag_d = tag_q + TAG_ONE;
      if (issue_now && !ROB_commit)
        credits_d = credits_q - CRED_ONE;
      else if (!issue_now && ROB_commit && credits_q != CRED_MAX)
        credits_d = credits_q + CRED_ONE;
    end
  end

  // Control state: FSM, credits, tag and the dispatch pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      credits_q   <= CRED_MAX;
      tag_q       <= '0;
      dsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      tag_q       <= tag_d;
      dsp_valid_q <= issue_now;
    end
  end

  // Holding register captures the queue head on every pop.
  always_ff @(posedge clk) begin
    if (pop) begin
      hold_inst_q <= IQ_inst;
      hold_pc_q   <= IQ_pc;
    end
  end

  // Dispatch payload persists between issues so stalls keep the last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      dsp_inst_q <= '0;
      dsp_pc_q   <= '0;
      dsp_tag_q  <= '0;
      dsp_lsb_q  <= 1'b0;
    end else if (issue_now) begin
      dsp_inst_q <= hold_inst_q;
      dsp_pc_q   <= hold_pc_q;
      dsp_tag_q  <= tag_q;
      dsp_lsb_q  <= (cls == C_LSB);
    end
  end

  assign IQ_pop     = pop;
  assign DSP_valid  = dsp_valid_q;
  assign DSP_inst   = dsp_inst_q;
  assign DSP_pc     = dsp_pc_q;
  assign DSP_tag    = dsp_tag_q;
  assign DSP_to_lsb = dsp_lsb_q;
  assign credits    = credits_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl with a small InstQueue model feeding it.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, RS_is_full, LSB_is_full, ROB_commit;
  logic        IQ_valid, IQ_pop;
  logic [31:0] IQ_inst, IQ_pc;
  logic        DSP_valid, DSP_to_lsb;
  logic [31:0] DSP_inst, DSP_pc;
  logic [3:0]  DSP_tag;
  logic [4:0]  credits;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_inst [0:31];
  logic [31:0] q_pc   [0:31];
  int          q_n    = 0;
  int          q_i    = 0;
  logic        q_clr  = 1'b1;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW   = 32'h00002083;
  localparam logic [31:0] ILL  = 32'h0000007F;

  always #5 clk = ~clk;

  // Queue model: head advances on every pop the DUT takes.
  always @(posedge clk) begin
    if (q_clr) q_i <= 0;
    else if (IQ_pop) q_i <= q_i + 1;
  end

  always_comb begin
    IQ_valid = (q_i < q_n);
    IQ_inst  = IQ_valid ? q_inst[q_i] : 32'h0;
    IQ_pc    = IQ_valid ? q_pc[q_i] : 32'h0;
  end

  issue_ctrl #(.ROB_SIZE(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .IQ_valid(IQ_valid), .IQ_inst(IQ_inst), .IQ_pc(IQ_pc), .IQ_pop(IQ_pop),
    .RS_is_full(RS_is_full), .LSB_is_full(LSB_is_full), .ROB_commit(ROB_commit),
    .DSP_valid(DSP_valid), .DSP_inst(DSP_inst), .DSP_pc(DSP_pc),
    .DSP_tag(DSP_tag), .DSP_to_lsb(DSP_to_lsb), .credits(credits)
  );

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Fill the queue with n copies of inst at consecutive PCs from base.
  task automatic fill(input int first, input int n, input logic [31:0] inst,
                      input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      q_inst[first+k] = inst;
      q_pc[first+k]   = base + 32'(4*k);
    end
    if (first + n > q_n) q_n = first + n;
  endtask

  // Two reset cycles; returns in the first cycle with rst low (cycle 0).
  task automatic do_reset(input string tag);
    rst = 1'b1; q_clr = 1'b1; rdy = 1'b1; flush = 1'b0;
    RS_is_full = 1'b0; LSB_is_full = 1'b0; ROB_commit = 1'b0;
    cyc(); cyc(); settle();
    check_eq({tag, "_rst_pop"}, IQ_pop, 0);
    check_eq({tag, "_rst_dv"}, DSP_valid, 0);
    check_eq({tag, "_rst_cred"}, credits, 16);
    check_eq({tag, "_rst_tag"}, DSP_tag, 0);
    check_eq({tag, "_rst_pc"}, DSP_pc, 0);
    rst = 1'b0; q_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-to-back ADDIs
    q_n = 0; fill(0, 3, ADDI, 32'h0);
    do_reset("s1");
    settle(); check_eq("s1_pop0", IQ_pop, 1);
    cyc(); settle(); check_eq("s1_pop1", IQ_pop, 1); check_eq("s1_dv1", DSP_valid, 0);
    cyc(); settle(); check_eq("s1_pop2", IQ_pop, 1); check_eq("s1_dv2", DSP_valid, 1);
    check_eq("s1_tag0", DSP_tag, 0); check_eq("s1_lsb0", DSP_to_lsb, 0);
    check_eq("s1_inst0", DSP_inst, ADDI);
    cyc(); settle(); check_eq("s1_pop3", IQ_pop, 0); check_eq("s1_dv3", DSP_valid, 1);
    check_eq("s1_tag1", DSP_tag, 1); check_eq("s1_pc1", DSP_pc, 4);
    cyc(); settle(); check_eq("s1_dv4", DSP_valid, 1); check_eq("s1_tag2", DSP_tag, 2);
    check_eq("s1_cred", credits, 13);
    cyc(); settle(); check_eq("s1_dv5", DSP_valid, 0);

    // LW stalled by a full LS Buffer
    q_n = 0; fill(0, 1, LW, 32'h100); fill(1, 1, ADDI, 32'h104);
    do_reset("s2");
    LSB_is_full = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(); settle();
      check_eq("s2_stall_pop", IQ_pop, 0); check_eq("s2_stall_dv", DSP_valid, 0);
    end
    cyc(); LSB_is_full = 1'b0; settle(); check_eq("s2_rel_pop", IQ_pop, 1);
    cyc(); settle(); check_eq("s2_dv", DSP_valid, 1); check_eq("s2_pc", DSP_pc, 32'h100);
    check_eq("s2_lsb", DSP_to_lsb, 1); check_eq("s2_inst", DSP_inst, LW);
    cyc(); settle(); check_eq("s2_dv_next", DSP_valid, 1);
    check_eq("s2_pc_next", DSP_pc, 32'h104); check_eq("s2_lsb_next", DSP_to_lsb, 0);

    // Credit exhaustion and tag wrap
    q_n = 0; fill(0, 17, ADDI, 32'h0);
    do_reset("s3");
    repeat (17) cyc();
    settle(); check_eq("s3_dv15", DSP_valid, 1); check_eq("s3_tag15", DSP_tag, 15);
    check_eq("s3_cred0", credits, 0);
    cyc(); settle(); check_eq("s3_nodsp", DSP_valid, 0); check_eq("s3_cred0b", credits, 0);
    cyc(); ROB_commit = 1'b1; settle(); check_eq("s3_nodsp2", DSP_valid, 0);
    cyc(); ROB_commit = 1'b0; settle(); check_eq("s3_cred1", credits, 1);
    cyc(); settle(); check_eq("s3_dv_wrap", DSP_valid, 1); check_eq("s3_tag_wrap", DSP_tag, 0);
    check_eq("s3_pc_wrap", DSP_pc, 64); check_eq("s3_cred_back", credits, 0);

    // Illegal opcode dropped
    q_n = 0; fill(0, 1, ILL, 32'h200); fill(1, 1, ADDI, 32'h204);
    do_reset("s4");
    cyc(); settle(); check_eq("s4_drop_pop", IQ_pop, 1);
    cyc(); settle(); check_eq("s4_dv", DSP_valid, 0); check_eq("s4_cred", credits, 16);
    cyc(); settle(); check_eq("s4_dv_next", DSP_valid, 1); check_eq("s4_pc", DSP_pc, 32'h204);
    check_eq("s4_tag", DSP_tag, 0); check_eq("s4_cred_next", credits, 15);

    // Issue+commit overlap, then flush in a stalled HOLD with tag 5 / credits 10
    q_n = 0; fill(0, 23, ADDI, 32'h0);
    do_reset("s5");
    ROB_commit = 1'b1;
    repeat (15) cyc();
    settle(); check_eq("s5_overlap_cred", credits, 16);
    cyc(); ROB_commit = 1'b0;
    repeat (5) cyc();
    cyc(); RS_is_full = 1'b1; settle();
    check_eq("s5_cred10", credits, 10); check_eq("s5_tag4", DSP_tag, 4);
    check_eq("s5_stall_pop", IQ_pop, 0);
    cyc(); flush = 1'b1; settle(); check_eq("s5_flush_pop", IQ_pop, 0);
    cyc(); flush = 1'b0; settle(); check_eq("s5_fl_pop", IQ_pop, 0);
    check_eq("s5_fl_cred", credits, 16); check_eq("s5_fl_dv", DSP_valid, 0);
    cyc(); RS_is_full = 1'b0; settle(); check_eq("s5_idle_pop", IQ_pop, 1);
    cyc(); cyc(); settle(); check_eq("s5_dv", DSP_valid, 1);
    check_eq("s5_tag0", DSP_tag, 0); check_eq("s5_pc", DSP_pc, 88);

    // rdy low for 3 cycles mid-stream, commit ignored meanwhile
    q_n = 0; fill(0, 6, ADDI, 32'h0);
    do_reset("s6");
    cyc();
    cyc(); rdy = 1'b0; settle(); check_eq("s6_frz_pop", IQ_pop, 0);
    check_eq("s6_dv_prior", DSP_valid, 1); check_eq("s6_tag_prior", DSP_tag, 0);
    cyc(); ROB_commit = 1'b1; settle(); check_eq("s6_frz_dv", DSP_valid, 0);
    cyc(); ROB_commit = 1'b0; settle(); check_eq("s6_frz_cred", credits, 15);
    check_eq("s6_frz_pop2", IQ_pop, 0);
    cyc(); rdy = 1'b1; settle(); check_eq("s6_res_pop", IQ_pop, 1);
    cyc(); settle(); check_eq("s6_res_dv", DSP_valid, 1); check_eq("s6_res_tag", DSP_tag, 1);
    check_eq("s6_res_pc", DSP_pc, 4); check_eq("s6_res_cred", credits, 14);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
